// File: rtl/ascon_finalize.sv
// Ascon-128 finalization: key mixing, 12-round permutation and tag generation/compare.
// Contains the iterative permutation core (one round per clock) and the finalize FSM.

module ascon_permutation #(
  parameter int ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] state_in  [0:4],
  output logic [63:0] state_out [3:4],
  output logic        done
);

  localparam logic [3:0] RC_BASE = 4'(12 - ROUNDS);

  logic [319:0] x_q, x_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         run_q, run_d;
  logic         done_q, done_d;
  logic [3:0]   rc_idx_s;

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  // Round sequencing: load on start when idle, then one round per cycle.
  always_comb begin
    x_d      = x_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    rc_idx_s = cnt_q + RC_BASE;
    if (run_q) begin
      x_d   = ascon_round(x_q, {4'hF - rc_idx_s, rc_idx_s});
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(ROUNDS - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else if (start) begin
      x_d   = {state_in[0], state_in[1], state_in[2], state_in[3], state_in[4]};
      cnt_d = 4'd0;
      run_d = 1'b1;
    end else begin
      run_d = 1'b0;
    end
  end

  // Permutation state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= 320'd0;
      cnt_q  <= 4'd0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign state_out[3] = x_q[127:64];
  assign state_out[4] = x_q[63:0];
  assign done         = done_q;

endmodule

module ascon_finalize #(
  parameter int ROUNDS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] state_in [0:4],
  input  logic [63:0] key      [0:1],
  input  logic [63:0] tag_ref  [0:1],
  output logic [63:0] tag      [0:1],
  output logic        tag_match,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_KEY_MIX    = 3'd1,
    ST_PERM_START = 3'd2,
    ST_PERM_WAIT  = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] s_q   [0:4];
  logic [63:0] s_d   [0:4];
  logic [63:0] k_q   [0:1];
  logic [63:0] k_d   [0:1];
  logic [63:0] r_q   [0:1];
  logic [63:0] r_d   [0:1];
  logic [63:0] tag_q [0:1];
  logic [63:0] tag_d [0:1];
  logic        tag_match_q, tag_match_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        perm_start_q, perm_start_d;
  logic [63:0] perm_state [3:4];
  logic        perm_done;
  logic [63:0] tag0_s, tag1_s;

  ascon_permutation #(.ROUNDS(ROUNDS)) u_perm (
    .clk       (clk),
    .rst_n     (~rst),
    .start     (perm_start_q),
    .state_in  (s_q),
    .state_out (perm_state),
    .done      (perm_done)
  );

  assign tag0_s = perm_state[3] ^ k_q[0];
  assign tag1_s = perm_state[4] ^ k_q[1];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:       state_d = start ? ST_KEY_MIX : ST_IDLE;
      ST_KEY_MIX:    state_d = ST_PERM_START;
      ST_PERM_START: state_d = ST_PERM_WAIT;
      ST_PERM_WAIT:  state_d = perm_done ? ST_DONE : ST_PERM_WAIT;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Datapath and output register updates for the current state.
  always_comb begin
    s_d          = s_q;
    k_d          = k_q;
    r_d          = r_q;
    tag_d        = tag_q;
    tag_match_d  = tag_match_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    perm_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d         = state_in;
          k_d         = key;
          r_d         = tag_ref;
          busy_d      = 1'b1;
          tag_match_d = 1'b0;
        end else begin
          busy_d      = 1'b0;
        end
      end
      ST_KEY_MIX: begin
        s_d[1] = s_q[1] ^ k_q[0];
        s_d[2] = s_q[2] ^ k_q[1];
      end
      ST_PERM_START: perm_start_d = 1'b1;
      ST_PERM_WAIT: begin
        if (perm_done) begin
          tag_d[0]    = tag0_s;
          tag_d[1]    = tag1_s;
          tag_match_d = (tag0_s == r_q[0]) && (tag1_s == r_q[1]);
          done_d      = 1'b1;
        end else begin
          done_d      = 1'b0;
        end
      end
      ST_DONE: busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q          <= '{default: 64'd0};
      k_q          <= '{default: 64'd0};
      r_q          <= '{default: 64'd0};
      tag_q        <= '{default: 64'd0};
      tag_match_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      s_q          <= s_d;
      k_q          <= k_d;
      r_q          <= r_d;
      tag_q        <= tag_d;
      tag_match_q  <= tag_match_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign tag[0]    = tag_q[0];
  assign tag[1]    = tag_q[1];
  assign tag_match = tag_match_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
